// File: rtl/pc_sequencer.sv
// pc_sequencer: phased program-counter sequencer with jump, call/return stack and halt
// ports: clk, rst (async, active high); run_en, stall, jflag, jdest, call, ret, halt_req in;
//        pc, phase, halted, ras_overflow, ras_underflow out (all registered)
module pc_sequencer #(
   parameter int              PC_W      = 12,
   parameter int              NPHASE    = 5,
   parameter int              UPD_PHASE = 2,
   parameter int              RAS_DEPTH = 4,
   parameter logic [PC_W-1:0] RESET_PC  = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            run_en,
   input  logic            stall,
   input  logic            jflag,
   input  logic [PC_W-1:0] jdest,
   input  logic            call,
   input  logic            ret,
   input  logic            halt_req,
   output logic [PC_W-1:0] pc,
   output logic [2:0]      phase,
   output logic            halted,
   output logic            ras_overflow,
   output logic            ras_underflow
);
   localparam int SP_W = $clog2(RAS_DEPTH) + 1;
   logic [PC_W-1:0] ras [RAS_DEPTH];
   logic [SP_W-1:0] sp;
   logic [SP_W-2:0] top;
   logic [PC_W-1:0] pc_inc, pc_nxt;
   logic            adv, upd, empty, full, do_push, do_pop, wrap;
   always_comb begin
      adv     = run_en & ~stall & ~halted;
      upd     = adv & (phase == 3'(UPD_PHASE));
      wrap    = phase == 3'(NPHASE - 1);
      pc_inc  = pc + 1'b1;
      empty   = sp == '0;
      full    = sp == SP_W'(RAS_DEPTH);
      top     = sp[SP_W-2:0] - 1'b1;
      do_pop  = upd & ret & ~empty;
      do_push = upd & ~ret & jflag & call & ~full;
      pc_nxt  = ret ? (empty ? pc_inc : ras[top]) : jflag ? jdest : pc_inc;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         pc            <= RESET_PC;
         phase         <= '0;
         halted        <= 1'b0;
         ras_overflow  <= 1'b0;
         ras_underflow <= 1'b0;
         sp            <= '0;
      end else if (adv) begin
         // a halt forces the phase back to 0 on the same edge as the final update
         phase <= ((upd & halt_req) | wrap) ? 3'd0 : phase + 3'd1;
         if (upd) begin
            pc <= pc_nxt;
            if (halt_req) halted <= 1'b1;
            if (ret & empty) ras_underflow <= 1'b1;
            if (~ret & jflag & call & full) ras_overflow <= 1'b1;
            if (do_pop) sp <= sp - 1'b1;
            if (do_push) sp <= sp + 1'b1;
         end
      end
   // stack storage needs no reset: an empty pointer makes every entry dead
   always_ff @(posedge clk)
      if (do_push) ras[sp[SP_W-2:0]] <= pc_inc;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized checks of pc_sequencer against a queue-based model
module tb_pc_sequencer;
   localparam int PC_W = 12, NPHASE = 5, UPD = 2, DEPTH = 4, PC_MOD = 1 << PC_W;
   logic            clk = 1'b0, rst = 1'b1, run_en = 1'b0, stall = 1'b0;
   logic            jflag = 1'b0, call = 1'b0, ret = 1'b0, halt_req = 1'b0;
   logic [PC_W-1:0] jdest = '0;
   logic [PC_W-1:0] pc;
   logic [2:0]      phase;
   logic            halted, ras_overflow, ras_underflow;
   int              vectors = 0, miscompares = 0;
   int              m_pc, m_phase, m_halted, m_ovf, m_unf;
   int              m_stk[$];
   int              lin[10] = '{0, 0, 0, 1, 1, 1, 1, 1, 2, 2};
   int              ret_exp[5] = '{'h121, 'h111, 'h101, 'h001, 'h002};

   pc_sequencer #(.PC_W(PC_W), .NPHASE(NPHASE), .UPD_PHASE(UPD), .RAS_DEPTH(DEPTH), .RESET_PC('0)) dut (
      .clk(clk), .rst(rst), .run_en(run_en), .stall(stall), .jflag(jflag), .jdest(jdest),
      .call(call), .ret(ret), .halt_req(halt_req), .pc(pc), .phase(phase), .halted(halted),
      .ras_overflow(ras_overflow), .ras_underflow(ras_underflow));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      check("pc", 32'(pc), 32'(m_pc));
      check("phase", 32'(phase), 32'(m_phase));
      check("halted", 32'(halted), 32'(m_halted));
      check("ras_overflow", 32'(ras_overflow), 32'(m_ovf));
      check("ras_underflow", 32'(ras_underflow), 32'(m_unf));
   endtask

   task automatic model_reset();
      m_pc = 0; m_phase = 0; m_halted = 0; m_ovf = 0; m_unf = 0;
      m_stk.delete();
   endtask

   // one clock of the reference behaviour, applied to the inputs seen at the edge
   task automatic model_step();
      int nxt;
      if (!(run_en && !stall && !m_halted)) return;
      if (m_phase == UPD) begin
         nxt = (m_pc + 1) % PC_MOD;
         if (ret) begin
            if (m_stk.size() > 0) nxt = m_stk.pop_back();
            else m_unf = 1;
         end else if (jflag) begin
            if (call) begin
               if (m_stk.size() < DEPTH) m_stk.push_back((m_pc + 1) % PC_MOD);
               else m_ovf = 1;
            end
            nxt = int'(jdest);
         end
         m_pc = nxt;
         if (halt_req) m_halted = 1;
         m_phase = halt_req ? 0 : (m_phase + 1) % NPHASE;
      end else m_phase = (m_phase + 1) % NPHASE;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic idle();
      run_en = 1'b1; stall = 1'b0; jflag = 1'b0; call = 1'b0; ret = 1'b0; halt_req = 1'b0;
   endtask

   task automatic goto_upd();
      idle();
      for (int i = 0; i < NPHASE && m_phase != UPD; i++) tick();
      check("reach_upd", 32'(phase), 32'(UPD));
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      model_reset();
      #1 check_all();
      rst = 1'b0;
   endtask

   task automatic jump(input logic [PC_W-1:0] d, input logic c);
      goto_upd();
      jflag = 1'b1; call = c; jdest = d;
      tick();
      idle();
   endtask

   initial begin
      model_reset();
      #3 check_all();
      @(posedge clk); #1 rst = 1'b0;
      // linear run
      idle();
      for (int i = 0; i < 10; i++) begin
         check("linear_pc", 32'(pc), 32'(lin[i]));
         tick();
      end
      // call and return
      jump(12'h010, 1'b0);
      jump(12'h100, 1'b1);
      check("call_pc", 32'(pc), 32'h100);
      goto_upd(); ret = 1'b1; tick(); idle();
      check("ret_pc", 32'(pc), 32'h011);
      goto_upd(); ret = 1'b1; tick(); idle();
      check("ret_empty_pc", 32'(pc), 32'h012);
      check("ret_empty_unf", 32'(ras_underflow), 32'd1);
      // overflow then underflow
      do_reset();
      for (int k = 0; k < 5; k++) begin
         jump(PC_W'(12'h100 + k * 'h10), 1'b1);
         check("ovf_flag", 32'(ras_overflow), 32'(k == 4));
      end
      for (int k = 0; k < 5; k++) begin
         goto_upd(); ret = 1'b1; tick(); idle();
         check("ret_seq_pc", 32'(pc), 32'(ret_exp[k]));
         check("unf_flag", 32'(ras_underflow), 32'(k == 4));
      end
      // stall at the update phase, then wrap
      do_reset();
      jump(12'hFFF, 1'b0);
      goto_upd();
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("stall_pc", 32'(pc), 32'hFFF);
         check("stall_phase", 32'(phase), 32'(UPD));
      end
      stall = 1'b0; tick();
      check("wrap_pc", 32'(pc), 32'h000);
      // priority and halt
      do_reset();
      jump(12'h054, 1'b0);
      jump(12'h200, 1'b1);
      goto_upd();
      ret = 1'b1; jflag = 1'b1; call = 1'b1; halt_req = 1'b1; jdest = 12'h300;
      tick();
      check("halt_pc", 32'(pc), 32'h055);
      check("halt_flag", 32'(halted), 32'd1);
      check("halt_phase", 32'(phase), 32'd0);
      for (int k = 0; k < 6; k++) tick();
      check("halt_hold_pc", 32'(pc), 32'h055);
      // asynchronous reset mid-instruction
      do_reset();
      jump(12'h020, 1'b1);
      jump(12'h040, 1'b1);
      check("pre_rst_phase", 32'(phase), 32'd3);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check("async_pc", 32'(pc), 32'd0);
      check_all();
      #2 rst = 1'b0;
      goto_upd(); ret = 1'b1; tick(); idle();
      check("post_rst_unf", 32'(ras_underflow), 32'd1);
      check("post_rst_pc", 32'(pc), 32'd1);
      // randomized traffic
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         if (($urandom_range(0, 199) == 0) || (m_halted && $urandom_range(0, 9) == 0)) do_reset();
         run_en   = $urandom_range(0, 9) != 0;
         stall    = $urandom_range(0, 4) == 0;
         ret      = $urandom_range(0, 6) == 0;
         jflag    = $urandom_range(0, 3) == 0;
         call     = $urandom_range(0, 1) == 1;
         halt_req = $urandom_range(0, 49) == 0;
         jdest    = PC_W'($urandom);
         tick();
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
